// File: rtl/fir_top.sv
// Serial 64-tap FIR: coefficient RAM, input sample FIFO and one multiply-accumulate per clock.
// A run pops one sample, accumulates NTAPS products, then strobes the wrapped 32-bit sum on y.
`timescale 1ns/1ps
module fir_top #(
    parameter int NTAPS      = 64,
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                 clk_1mhz,
    input  logic                 rst,
    input  logic                 cload,
    input  logic signed [DW-1:0] cin,
    input  logic                 xload,
    input  logic                 wr_en,
    input  logic signed [DW-1:0] xin,
    input  logic                 rd_en,
    output logic signed [31:0]   y,
    output logic                 valid
);
    localparam int KW  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = 2 * DW;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]              state;
    logic [KW-1:0]           cptr;
    logic [KW-1:0]           k;
    logic signed [31:0]      acc;
    logic signed [DW-1:0]    cmem [NTAPS];
    logic signed [DW-1:0]    xbuf [NTAPS];
    logic signed [DW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0]          wr_ptr;
    logic [FAW-1:0]          rd_ptr;
    logic [CW-1:0]           fcnt;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;

    // Full-precision signed product, accumulated modulo 2^32 with no saturation.
    function automatic logic signed [31:0] mac_wrap(input logic signed [31:0] a,
                                                    input logic signed [DW-1:0] c,
                                                    input logic signed [DW-1:0] x);
        logic signed [PW-1:0] prod;
        prod = PW'(c) * PW'(x);
        return a + 32'(prod);
    endfunction

    function automatic logic [FAW-1:0] ptr_next(input logic [FAW-1:0] p);
        return (p == FAW'(FIFO_DEPTH - 1)) ? '0 : p + FAW'(1);
    endfunction

    assign fifo_empty = (fcnt == '0);
    assign fifo_full  = (fcnt == CW'(FIFO_DEPTH));
    assign pop        = (state == IDLE) && rd_en && !fifo_empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO is accepted then.
    assign push       = xload && wr_en && (!fifo_full || pop);

    always_ff @(posedge clk_1mhz) begin
        if (push)
            fifo_mem[wr_ptr] <= xin;
    end

    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_next(wr_ptr);
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   fcnt <= fcnt + CW'(1);
                2'b01:   fcnt <= fcnt - CW'(1);
                default: fcnt <= fcnt;
            endcase
        end
    end

    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cptr  <= '0;
            k     <= '0;
            acc   <= '0;
            y     <= '0;
            valid <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                cmem[i] <= '0;
                xbuf[i] <= '0;
            end
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cload) begin
                        cmem[cptr] <= cin;
                        cptr       <= (cptr == KW'(NTAPS - 1)) ? '0 : cptr + KW'(1);
                    end
                    if (pop) begin
                        for (int i = NTAPS - 1; i > 0; i--)
                            xbuf[i] <= xbuf[i-1];
                        xbuf[0] <= fifo_mem[rd_ptr];
                        acc     <= '0;
                        k       <= '0;
                        state   <= MAC;
                    end
                end
                // One tap per clock; the last tap hands off to the output stage.
                MAC: begin
                    acc <= mac_wrap(acc, cmem[k], xbuf[k]);
                    if (k == KW'(NTAPS - 1)) begin
                        k     <= '0;
                        state <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    y     <= acc;
                    valid <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_top.sv
// Scoreboard bench for fir_top: expected outputs are queued as samples are pushed and
// compared against y on every valid strobe.
`timescale 1ns/1ps
module tb_fir_top;
    logic               clk_1mhz = 1'b0;
    logic               rst      = 1'b1;
    logic               cload    = 1'b0;
    logic signed [15:0] cin      = '0;
    logic               xload    = 1'b0;
    logic               wr_en    = 1'b0;
    logic signed [15:0] xin      = '0;
    logic               rd_en    = 1'b0;
    logic signed [31:0] y;
    logic               valid;

    int          total  = 0;
    int          bad    = 0;
    int          nvalid = 0;
    longint      cyc    = 0;
    logic [31:0] expq [$];
    longint      vcyc [$];
    logic signed [15:0] mcoef [64];
    logic signed [15:0] mx    [64];

    fir_top #(.NTAPS(64), .DW(16), .FIFO_DEPTH(64)) dut (
        .clk_1mhz (clk_1mhz),
        .rst      (rst),
        .cload    (cload),
        .cin      (cin),
        .xload    (xload),
        .wr_en    (wr_en),
        .xin      (xin),
        .rd_en    (rd_en),
        .y        (y),
        .valid    (valid)
    );

    always #500 clk_1mhz = ~clk_1mhz;
    always @(posedge clk_1mhz) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_y();
        logic signed [31:0] a;
        a = 0;
        for (int i = 0; i < 64; i++)
            a = a + mcoef[i] * mx[i];
        return a;
    endfunction

    initial begin
        forever begin
            @(negedge clk_1mhz);
            if (valid) begin
                nvalid++;
                vcyc.push_back(cyc);
                if (expq.size() == 0)
                    check("spurious_valid", 32'd1, 32'd0);
                else
                    check("y", y, expq.pop_front());
            end
        end
    end

    task automatic do_reset();
        rd_en = 1'b0; cload = 1'b0; xload = 1'b0; wr_en = 1'b0;
        rst = 1'b1;
        expq.delete();
        vcyc.delete();
        for (int i = 0; i < 64; i++) begin
            mcoef[i] = '0;
            mx[i]    = '0;
        end
        #1;
        check("rst_y", y, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        repeat (3) @(posedge clk_1mhz);
        #1;
        rst = 1'b0;
    endtask

    task automatic load_coefs();
        for (int i = 0; i < 64; i++) begin
            cload = 1'b1;
            cin   = mcoef[i];
            @(posedge clk_1mhz);
            #1;
        end
        cload = 1'b0;
    endtask

    task automatic push_sample(input logic [15:0] v, input bit accepted);
        xload = 1'b1;
        wr_en = 1'b1;
        xin   = v;
        if (accepted) begin
            for (int i = 63; i > 0; i--)
                mx[i] = mx[i-1];
            mx[0] = v;
            expq.push_back(model_y());
        end
        @(posedge clk_1mhz);
        #1;
        xload = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (expq.size() != 0 && n < budget) begin
            @(posedge clk_1mhz);
            n++;
        end
        #1;
        check("drain", expq.size(), 32'd0);
    endtask

    initial begin
        #(60000 * 1000);
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int     n0;
        longint c0;

        // Empty FIFO: rd_en alone must never start a run.
        do_reset();
        n0 = nvalid;
        rd_en = 1'b1;
        repeat (150) @(posedge clk_1mhz);
        #1;
        rd_en = 1'b0;
        check("empty_rd_valids", nvalid - n0, 32'd0);

        // Impulse through ramp coefficients, with latency and spacing.
        do_reset();
        for (int i = 0; i < 64; i++) mcoef[i] = 16'(i + 1);
        load_coefs();
        push_sample(16'd1, 1'b1);
        push_sample(16'd0, 1'b1);
        push_sample(16'd0, 1'b1);
        push_sample(16'd0, 1'b1);
        vcyc.delete();
        rd_en = 1'b1;
        c0 = cyc + 1;
        wait_drain(4 * 66 + 100);
        rd_en = 1'b0;
        check("impulse_count", vcyc.size(), 32'd4);
        if (vcyc.size() == 4) begin
            check("latency", 32'(vcyc[0] - c0), 32'd65);
            for (int i = 1; i < 4; i++)
                check("spacing", 32'(vcyc[i] - vcyc[i-1]), 32'd66);
        end

        // Moving sum of ones.
        do_reset();
        for (int i = 0; i < 64; i++) mcoef[i] = 16'sd1;
        load_coefs();
        for (int i = 0; i < 64; i++) push_sample(16'd1, 1'b1);
        n0 = nvalid;
        rd_en = 1'b1;
        wait_drain(64 * 66 + 100);
        rd_en = 1'b0;
        check("msum_count", nvalid - n0, 32'd64);
        check("msum_last", y, 32'd64);

        // Negative coefficient.
        do_reset();
        mcoef[0] = 16'shFFFE;
        load_coefs();
        push_sample(16'd3, 1'b1);
        rd_en = 1'b1;
        wait_drain(200);
        rd_en = 1'b0;
        check("sign_y", y, 32'hFFFF_FFFA);

        // Overflow drop, then push and pop on the same edge while full.
        do_reset();
        for (int i = 0; i < 64; i++) mcoef[i] = 16'((i % 7) - 3);
        load_coefs();
        for (int i = 0; i < 64; i++) push_sample(16'(i + 1), 1'b1);
        push_sample(16'd1000, 1'b0);
        n0 = nvalid;
        rd_en = 1'b1;
        push_sample(16'd2000, 1'b1);
        wait_drain(65 * 66 + 100);
        repeat (200) @(posedge clk_1mhz);
        #1;
        rd_en = 1'b0;
        check("fifo_valids", nvalid - n0, 32'd65);

        // Reset 20 clocks into a run aborts it.
        do_reset();
        for (int i = 0; i < 64; i++) mcoef[i] = 16'sd1;
        load_coefs();
        push_sample(16'd5, 1'b1);
        rd_en = 1'b1;
        @(posedge clk_1mhz);
        #1;
        rd_en = 1'b0;
        repeat (20) @(posedge clk_1mhz);
        #1;
        n0 = nvalid;
        do_reset();
        repeat (100) @(posedge clk_1mhz);
        #1;
        check("midrst_valids", nvalid - n0, 32'd0);
        check("midrst_y", y, 32'd0);
        n0 = nvalid;
        push_sample(16'd7, 1'b1);
        rd_en = 1'b1;
        wait_drain(200);
        rd_en = 1'b0;
        check("zero_run_valids", nvalid - n0, 32'd1);
        check("zero_y", y, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
